// File: rtl/game_pkg.sv
// Shared definitions for the tic-tac-toe judge: colours, board size, the
// table of winning lines, FSM state encoding and a popcount helper.
// No ports; imported by game_judge and line_eval.
package game_pkg;

   localparam logic BLUE    = 1'b0;
   localparam logic YELLOW  = 1'b1;
   localparam int   BOARD_N = 9;
   localparam int   LINE_N  = 8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PLAY,
      ST_CHECK,
      ST_RESULT,
      ST_CLEAR
   } state_t;

   // Square indices of winning line l, packed as {a, b, c}; a is the
   // square whose colour represents the line.
   function automatic logic [11:0] line_sq(input int l);
      logic [11:0] t;
      case (l)
         0:       t = {4'd0, 4'd1, 4'd2};
         1:       t = {4'd3, 4'd4, 4'd5};
         2:       t = {4'd6, 4'd7, 4'd8};
         3:       t = {4'd0, 4'd3, 4'd6};
         4:       t = {4'd1, 4'd4, 4'd7};
         5:       t = {4'd2, 4'd5, 4'd8};
         6:       t = {4'd0, 4'd4, 4'd8};
         default: t = {4'd2, 4'd4, 4'd6};
      endcase
      return t;
   endfunction

   function automatic logic [3:0] popcount9(input logic [BOARD_N-1:0] v);
      logic [3:0] n;
      n = '0;
      for (int i = 0; i < BOARD_N; i++) begin
         n = n + 4'(v[i]);
      end
      return n;
   endfunction

endpackage

// File: rtl/game_judge_line_eval.sv
// Combinational evaluation of all 8 winning lines of a board snapshot.
// Ports: occ/col = snapshot occupancy and colour; win_line = one bit per
// complete line; first_color = colour of lowest-index complete line; full = all occupied.
module line_eval
   import game_pkg::*;
(
   input  logic [BOARD_N-1:0] occ,
   input  logic [BOARD_N-1:0] col,
   output logic [LINE_N-1:0]  win_line,
   output logic               first_color,
   output logic               full
);

   logic [LINE_N-1:0] line_col;

   for (genvar l = 0; l < LINE_N; l++) begin : g_line
      localparam logic [11:0] SQ = line_sq(l);
      localparam logic [3:0]  A  = SQ[11:8];
      localparam logic [3:0]  B  = SQ[7:4];
      localparam logic [3:0]  C  = SQ[3:0];

      assign win_line[l] = occ[A] & occ[B] & occ[C]
                         & (col[A] == col[B]) & (col[B] == col[C]);
      assign line_col[l] = col[A];
   end

   // Scan from the top down so the lowest-index complete line is the last
   // one written; this settles the mixed-colour case deterministically.
   always_comb begin
      first_color = BLUE;
      for (int l = LINE_N-1; l >= 0; l--) begin
         if (win_line[l]) begin
            first_color = line_col[l];
         end
      end
   end

   assign full = &occ;

endmodule

// File: rtl/game_judge.sv
// Game judge: snapshots the board on every change, evaluates lines, declares
// win/draw, holds the result, then requests a board clear via new_game.
// Ports: pclk/rst (sync, active-high); start_en; square1to9 (occupancy),
// square1to9_color; restart_req; outputs game_over, winner_valid,
// winner_color, draw, win_line, move_count, turn, new_game.
module game_judge
   import game_pkg::*;
#(
   parameter int HOLD_CYCLES = 65_000_000,
   parameter int CNT_W       = $clog2(HOLD_CYCLES + 1)
)
(
   input  logic               pclk,
   input  logic               rst,
   input  logic               start_en,
   input  logic [BOARD_N-1:0] square1to9,
   input  logic [BOARD_N-1:0] square1to9_color,
   input  logic               restart_req,
   output logic               game_over,
   output logic               winner_valid,
   output logic               winner_color,
   output logic               draw,
   output logic [LINE_N-1:0]  win_line,
   output logic [3:0]         move_count,
   output logic               turn,
   output logic               new_game
);

   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   state_t             state, state_nx;
   logic [BOARD_N-1:0] snap_occ, snap_occ_nx;
   logic [BOARD_N-1:0] snap_col, snap_col_nx;
   logic [CNT_W-1:0]   hold_cnt, hold_cnt_nx;
   logic [LINE_N-1:0]  win_line_nx;
   logic               winner_valid_nx;
   logic               winner_color_nx;
   logic               draw_nx;

   logic [LINE_N-1:0]  eval_line;
   logic               eval_color;
   logic               eval_full;

   line_eval u_line_eval (
      .occ         (snap_occ),
      .col         (snap_col),
      .win_line    (eval_line),
      .first_color (eval_color),
      .full        (eval_full)
   );

   always_ff @(posedge pclk) begin
      if (rst) begin
         state        <= ST_IDLE;
         snap_occ     <= '0;
         snap_col     <= '0;
         hold_cnt     <= '0;
         win_line     <= '0;
         winner_valid <= 1'b0;
         winner_color <= 1'b0;
         draw         <= 1'b0;
      end else begin
         state        <= state_nx;
         snap_occ     <= snap_occ_nx;
         snap_col     <= snap_col_nx;
         hold_cnt     <= hold_cnt_nx;
         win_line     <= win_line_nx;
         winner_valid <= winner_valid_nx;
         winner_color <= winner_color_nx;
         draw         <= draw_nx;
      end
   end

   always_comb begin
      state_nx        = state;
      snap_occ_nx     = snap_occ;
      snap_col_nx     = snap_col;
      hold_cnt_nx     = hold_cnt;
      win_line_nx     = win_line;
      winner_valid_nx = winner_valid;
      winner_color_nx = winner_color;
      draw_nx         = draw;

      if (!start_en) begin
         // Leaving the game screen wipes everything so IDLE shows all zeros.
         state_nx        = ST_IDLE;
         snap_occ_nx     = '0;
         snap_col_nx     = '0;
         hold_cnt_nx     = '0;
         win_line_nx     = '0;
         winner_valid_nx = 1'b0;
         winner_color_nx = 1'b0;
         draw_nx         = 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               snap_occ_nx = square1to9;
               snap_col_nx = square1to9_color;
               state_nx    = ST_PLAY;
            end
            ST_PLAY: begin
               // Any number of bits changing at once is one board change.
               if ({square1to9, square1to9_color} != {snap_occ, snap_col}) begin
                  snap_occ_nx = square1to9;
                  snap_col_nx = square1to9_color;
                  state_nx    = ST_CHECK;
               end
            end
            ST_CHECK: begin
               hold_cnt_nx = '0;
               if (|eval_line) begin
                  // Win is tested first so a completing 9th move is a win.
                  win_line_nx     = eval_line;
                  winner_color_nx = eval_color;
                  winner_valid_nx = 1'b1;
                  state_nx        = ST_RESULT;
               end else if (eval_full) begin
                  draw_nx  = 1'b1;
                  state_nx = ST_RESULT;
               end else begin
                  state_nx = ST_PLAY;
               end
            end
            ST_RESULT: begin
               if (restart_req || (hold_cnt == HOLD_LAST)) begin
                  state_nx        = ST_CLEAR;
                  hold_cnt_nx     = '0;
                  win_line_nx     = '0;
                  winner_valid_nx = 1'b0;
                  winner_color_nx = 1'b0;
                  draw_nx         = 1'b0;
               end else begin
                  hold_cnt_nx = hold_cnt + CNT_ONE;
               end
            end
            ST_CLEAR: begin
               if (square1to9 == '0) begin
                  snap_occ_nx = '0;
                  snap_col_nx = '0;
                  state_nx    = ST_PLAY;
               end
            end
            default: begin
               state_nx = ST_IDLE;
            end
         endcase
      end
   end

   assign game_over  = (state == ST_RESULT) || (state == ST_CLEAR);
   assign new_game   = (state == ST_CLEAR);
   assign move_count = popcount9(snap_occ);
   assign turn       = move_count[0] ? YELLOW : BLUE;

endmodule

// File: tb/tb_game_judge.sv
module tb_game_judge;

   localparam int HOLD = 8;

   logic       pclk = 1'b0;
   logic       rst;
   logic       start_en;
   logic [8:0] square1to9;
   logic [8:0] square1to9_color;
   logic       restart_req;
   logic       game_over;
   logic       winner_valid;
   logic       winner_color;
   logic       draw;
   logic [7:0] win_line;
   logic [3:0] move_count;
   logic       turn;
   logic       new_game;

   int n_chk  = 0;
   int n_fail = 0;

   game_judge #(.HOLD_CYCLES(HOLD)) dut (
      .pclk             (pclk),
      .rst              (rst),
      .start_en         (start_en),
      .square1to9       (square1to9),
      .square1to9_color (square1to9_color),
      .restart_req      (restart_req),
      .game_over        (game_over),
      .winner_valid     (winner_valid),
      .winner_color     (winner_color),
      .draw             (draw),
      .win_line         (win_line),
      .move_count       (move_count),
      .turn             (turn),
      .new_game         (new_game)
   );

   always #5 pclk = ~pclk;

   typedef struct {
      logic [8:0] occ;
      logic [8:0] col;
      logic [7:0] wl;
      logic       wv;
      logic       wc;
      logic       dr;
      logic [3:0] mc;
      logic       go;
   } vec_t;

   vec_t vecs[8];

   task automatic tick();
      @(posedge pclk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic chk_zero(input string nm);
      chk({nm, ".game_over"}, game_over, 0);
      chk({nm, ".winner_valid"}, winner_valid, 0);
      chk({nm, ".winner_color"}, winner_color, 0);
      chk({nm, ".draw"}, draw, 0);
      chk({nm, ".win_line"}, win_line, 0);
      chk({nm, ".move_count"}, move_count, 0);
      chk({nm, ".turn"}, turn, 0);
      chk({nm, ".new_game"}, new_game, 0);
   endtask

   // Apply one board from an empty board in PLAY, check, then return to an
   // empty board in PLAY.
   task automatic apply_vec(input int i);
      string nm;
      nm = $sformatf("vec%0d", i);
      square1to9       = vecs[i].occ;
      square1to9_color = vecs[i].col;
      tick();
      chk({nm, ".move_n1"}, move_count, vecs[i].mc);
      chk({nm, ".result_n1"}, winner_valid | draw, 0);
      tick();
      chk({nm, ".win_line"}, win_line, vecs[i].wl);
      chk({nm, ".winner_valid"}, winner_valid, vecs[i].wv);
      chk({nm, ".winner_color"}, winner_color, vecs[i].wc);
      chk({nm, ".draw"}, draw, vecs[i].dr);
      chk({nm, ".move_count"}, move_count, vecs[i].mc);
      chk({nm, ".turn"}, turn, vecs[i].mc[0]);
      chk({nm, ".game_over"}, game_over, vecs[i].go);
      chk({nm, ".new_game"}, new_game, 0);
      if (vecs[i].go) begin
         restart_req = 1'b1;
         tick();
         restart_req = 1'b0;
         chk({nm, ".clr_new_game"}, new_game, 1);
         square1to9       = '0;
         square1to9_color = '0;
         tick();
      end else begin
         square1to9       = '0;
         square1to9_color = '0;
         tick();
         tick();
      end
      chk({nm, ".back_new_game"}, new_game, 0);
      chk({nm, ".back_move"}, move_count, 0);
      chk({nm, ".back_game_over"}, game_over, 0);
   endtask

   initial begin
      //             occ     col     wl     wv wc dr mc     go
      vecs[0] = '{9'h007, 9'h000, 8'h01, 1, 0, 0, 4'd3, 1}; // row 0 blue
      vecs[1] = '{9'h1FF, 9'h0E5, 8'h00, 0, 0, 1, 4'd9, 1}; // draw
      vecs[2] = '{9'h1FF, 9'h04F, 8'h09, 1, 1, 0, 4'd9, 1}; // row0+col0 on 9th move
      vecs[3] = '{9'h1C7, 9'h007, 8'h05, 1, 1, 0, 4'd6, 1}; // both colours, line 0 wins
      vecs[4] = '{9'h011, 9'h000, 8'h00, 0, 0, 0, 4'd2, 0}; // two bits at once, no line
      vecs[5] = '{9'h054, 9'h000, 8'h80, 1, 0, 0, 4'd3, 1}; // anti-diagonal
      vecs[6] = '{9'h092, 9'h092, 8'h10, 1, 1, 0, 4'd3, 1}; // middle column yellow
      vecs[7] = '{9'h007, 9'h002, 8'h00, 0, 0, 0, 4'd3, 0}; // row 0 mixed colours

      rst              = 1'b1;
      start_en         = 1'b1;
      square1to9       = '0;
      square1to9_color = '0;
      restart_req      = 1'b0;
      tick();
      tick();
      chk_zero("reset");
      rst = 1'b0;
      tick();
      chk_zero("play_entry");

      for (int i = 0; i < 8; i++) begin
         apply_vec(i);
      end

      // Interleaved game: blue 0,1,2 against yellow 3,4, one move per 4 cycles.
      begin
         logic [8:0] occ_seq [5];
         logic [8:0] col_seq [5];
         occ_seq = '{9'h001, 9'h009, 9'h00B, 9'h01B, 9'h01F};
         col_seq = '{9'h000, 9'h008, 9'h008, 9'h018, 9'h018};
         for (int m = 0; m < 5; m++) begin
            square1to9       = occ_seq[m];
            square1to9_color = col_seq[m];
            if (m < 4) begin
               for (int k = 0; k < 4; k++) tick();
               chk($sformatf("game.m%0d_move", m), move_count, m + 1);
               chk($sformatf("game.m%0d_valid", m), winner_valid, 0);
            end
         end
         tick();
         tick();
         chk("game.win_line", win_line, 8'h01);
         chk("game.winner_color", winner_color, 0);
         chk("game.winner_valid", winner_valid, 1);
         chk("game.move_count", move_count, 5);
         chk("game.game_over", game_over, 1);
         for (int k = 1; k < HOLD; k++) begin
            if (k == 3) square1to9 = 9'h03F;
            tick();
            chk($sformatf("game.hold%0d_new_game", k), new_game, 0);
         end
         chk("game.frozen_line", win_line, 8'h01);
         chk("game.frozen_move", move_count, 5);
         tick();
         chk("game.clear_new_game", new_game, 1);
         chk("game.clear_valid", winner_valid, 0);
         chk("game.clear_line", win_line, 0);
         chk("game.clear_game_over", game_over, 1);
         tick();
         chk("game.clear_wait", new_game, 1);
         square1to9       = '0;
         square1to9_color = '0;
         tick();
         chk("game.done_new_game", new_game, 0);
         chk("game.done_move", move_count, 0);
         chk("game.done_game_over", game_over, 0);
      end

      // Early restart in RESULT cycle 2.
      square1to9 = 9'h1C0;
      tick();
      tick();
      chk("rr.valid", winner_valid, 1);
      chk("rr.line", win_line, 8'h04);
      tick();
      tick();
      restart_req = 1'b1;
      tick();
      restart_req = 1'b0;
      chk("rr.new_game", new_game, 1);
      chk("rr.valid_clr", winner_valid, 0);
      square1to9 = '0;
      tick();
      chk("rr.back", new_game, 0);

      // Reset during RESULT.
      square1to9       = 9'h007;
      square1to9_color = 9'h007;
      tick();
      tick();
      chk("rst.color_before", winner_color, 1);
      rst = 1'b1;
      tick();
      chk_zero("rst_result");
      rst              = 1'b0;
      square1to9       = '0;
      square1to9_color = '0;
      tick();
      tick();
      chk("rst.move_after", move_count, 0);

      // Drop start_en in PLAY.
      square1to9 = 9'h001;
      tick();
      tick();
      chk("idle.move_before", move_count, 1);
      start_en = 1'b0;
      tick();
      chk_zero("idle");
      tick();
      chk("idle.new_game_hold", new_game, 0);
      square1to9 = '0;
      start_en   = 1'b1;
      tick();
      chk("idle.replay_move", move_count, 0);
      chk("idle.replay_new_game", new_game, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
